// File: rtl/conv_pkg.sv
// Shared definitions for the streaming convolution engine: log2 helpers,
// pipeline depth functions and the weight-commit FSM state type.
package conv_pkg;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((longint'(1) << r) < longint'(n)) r++;
    return r;
  endfunction

  // Address ports need at least one bit even for a single-tap kernel.
  function automatic int unsigned addr_w(input int unsigned n);
    return (clog2(n) > 0) ? clog2(n) : 1;
  endfunction

  function automatic int unsigned tree_lvl(input int unsigned kernel_num);
    return clog2(kernel_num);
  endfunction

  function automatic int unsigned lat(input int unsigned kernel_num);
    return 3 + tree_lvl(kernel_num);
  endfunction

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_PEND = 1'b1
  } wgt_st_e;

endpackage

// File: rtl/conv_add_tree.sv
// Pipelined binary adder tree: N unsigned inputs of IW bits, one register
// per level, with a valid bit travelling alongside the data.
module conv_add_tree
  import conv_pkg::*;
#(
  parameter int unsigned N  = 9,
  parameter int unsigned IW = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_vld,
  input  logic [N*IW-1:0]         i_data,
  output logic                    o_vld,
  output logic [IW+clog2(N)-1:0]  o_sum
);

  localparam int unsigned LVL = clog2(N);
  localparam int unsigned OW  = IW + LVL;
  localparam int unsigned NP  = 1 << LVL;

  logic [OW-1:0] w_leaf [NP];

  for (genvar g = 0; g < NP; g++) begin : g_leaf
    if (g < N) begin : g_in
      assign w_leaf[g] = OW'(i_data[g*IW +: IW]);
    end else begin : g_pad
      assign w_leaf[g] = '0;
    end
  end

  if (LVL == 0) begin : g_pass
    assign o_sum = w_leaf[0];
    assign o_vld = i_vld;
  end else begin : g_tree
    // Heap layout: node k has children 2k+1 / 2k+2; nodes NP-1.. are leaves,
    // so every leaf sits at the same depth and each level is one register.
    logic [OW-1:0]  r_node [NP-1];
    logic [LVL-1:0] r_vld;

    for (genvar k = 0; k < NP - 1; k++) begin : g_node
      logic [OW-1:0] w_a;
      logic [OW-1:0] w_b;
      if (2*k + 2 < NP - 1) begin : g_int
        assign w_a = r_node[2*k + 1];
        assign w_b = r_node[2*k + 2];
      end else begin : g_lf
        assign w_a = w_leaf[2*k + 2 - NP];
        assign w_b = w_leaf[2*k + 3 - NP];
      end

      always_ff @(posedge clk) begin
        if (rst) r_node[k] <= '0;
        else     r_node[k] <= w_a + w_b;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) r_vld <= '0;
      else     r_vld <= (r_vld << 1) | LVL'(i_vld);
    end

    assign o_sum = r_node[0];
    assign o_vld = r_vld[LVL-1];
  end

endmodule

// File: rtl/conv_krn_pipe.sv
// Streaming KRNV_SZ x KRNH_SZ convolver with double-buffered weights committed
// at line starts. Define CONV_RND_SAT_EN for round-half-up and saturation.
module conv_krn_pipe
  import conv_pkg::*;
#(
  parameter int unsigned KRNV_SZ    = 5,
  parameter int unsigned KRNH_SZ    = 5,
  parameter int unsigned CIW        = 8,
  parameter int unsigned FILTER_WTH = 8,
  parameter int unsigned FRAC_WTH   = 8,
  parameter int unsigned COW        = 12
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  i_vld,
  input  logic                                  i_hstr,
  input  logic [CIW*KRNV_SZ-1:0]                i_data,
  input  logic                                  i_wgt_wr,
  input  logic [addr_w(KRNV_SZ*KRNH_SZ)-1:0]    i_wgt_addr,
  input  logic [FILTER_WTH-1:0]                 i_wgt_data,
  input  logic                                  i_wgt_cmt,
  output logic [COW-1:0]                        o_data,
  output logic                                  o_vld,
  output logic                                  o_wgt_pend
);

  localparam int unsigned KERNEL_NUM = KRNV_SZ * KRNH_SZ;
  localparam int unsigned WA_W       = addr_w(KERNEL_NUM);
  localparam int unsigned TL         = tree_lvl(KERNEL_NUM);
  localparam int unsigned PW         = CIW + FILTER_WTH;
  localparam int unsigned AW         = PW + TL;
  localparam int unsigned CW         = clog2(KRNH_SZ + 1);
  localparam int unsigned RW         = (AW >= COW) ? AW + 1 : COW + 1;

  wgt_st_e                r_wst;
  wgt_st_e                w_wst_nxt;
  logic                   w_line_st;
  logic                   w_apply;
  logic [FILTER_WTH-1:0]  r_shd     [KERNEL_NUM];
  logic [FILTER_WTH-1:0]  r_act     [KERNEL_NUM];
  logic [FILTER_WTH-1:0]  w_shd_nxt [KERNEL_NUM];

  logic [CW-1:0]          r_col_cnt;
  logic [CW-1:0]          w_col_nxt;
  logic                   w_win_done;
  logic [CIW-1:0]         r_win [KRNH_SZ][KRNV_SZ];
  logic                   r_win_vld;

  logic [PW-1:0]          r_prod [KERNEL_NUM];
  logic [KERNEL_NUM*PW-1:0] w_prod_flat;
  logic                   r_mul_vld;

  logic [AW-1:0]          w_sum;
  logic                   w_sum_vld;
  logic [RW-1:0]          w_ext;
  logic [COW-1:0]         w_res;

  assign w_line_st  = i_vld & i_hstr;
  assign o_wgt_pend = (r_wst == W_PEND);

  // Weight commit FSM
  always_comb begin
    w_wst_nxt = r_wst;
    w_apply   = 1'b0;
    case (r_wst)
      W_IDLE: begin
        if (i_wgt_cmt && w_line_st) w_apply = 1'b1;
        else if (i_wgt_cmt)         w_wst_nxt = W_PEND;
      end
      W_PEND: begin
        if (w_line_st) begin
          w_apply   = 1'b1;
          w_wst_nxt = W_IDLE;
        end
      end
      default: w_wst_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_wst <= W_IDLE;
    else     r_wst <= w_wst_nxt;
  end

  // Same-cycle write lands in the shadow bank before it is copied.
  always_comb begin
    for (int unsigned k = 0; k < KERNEL_NUM; k++) begin
      w_shd_nxt[k] = (i_wgt_wr && (i_wgt_addr == WA_W'(k))) ? i_wgt_data : r_shd[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < KERNEL_NUM; k++) begin
        r_shd[k] <= '0;
        r_act[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < KERNEL_NUM; k++) begin
        r_shd[k] <= w_shd_nxt[k];
        if (w_apply) r_act[k] <= w_shd_nxt[k];
      end
    end
  end

  always_comb begin
    w_col_nxt = r_col_cnt;
    if (i_hstr)                          w_col_nxt = CW'(1);
    else if (r_col_cnt != CW'(KRNH_SZ))  w_col_nxt = r_col_cnt + 1'b1;
  end

  assign w_win_done = i_vld && (w_col_nxt == CW'(KRNH_SZ));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col_cnt <= '0;
      r_win_vld <= 1'b0;
      for (int unsigned h = 0; h < KRNH_SZ; h++) begin
        for (int unsigned v = 0; v < KRNV_SZ; v++) r_win[h][v] <= '0;
      end
    end else begin
      r_win_vld <= w_win_done;
      if (i_vld) begin
        r_col_cnt <= w_col_nxt;
        for (int unsigned h = 0; h + 1 < KRNH_SZ; h++) begin
          for (int unsigned v = 0; v < KRNV_SZ; v++) r_win[h][v] <= r_win[h+1][v];
        end
        for (int unsigned v = 0; v < KRNV_SZ; v++) begin
          r_win[KRNH_SZ-1][v] <= i_data[v*CIW +: CIW];
        end
      end
    end
  end

  // r_act only changes on the edge that loads a line's first column, so the
  // bank seen here is always the one in force when this window was loaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mul_vld <= 1'b0;
      for (int unsigned k = 0; k < KERNEL_NUM; k++) r_prod[k] <= '0;
    end else begin
      r_mul_vld <= r_win_vld;
      for (int unsigned h = 0; h < KRNH_SZ; h++) begin
        for (int unsigned v = 0; v < KRNV_SZ; v++) begin
          r_prod[h*KRNV_SZ + v] <= PW'(r_win[h][v]) * PW'(r_act[h*KRNV_SZ + v]);
        end
      end
    end
  end

  always_comb begin
    w_prod_flat = '0;
    for (int unsigned k = 0; k < KERNEL_NUM; k++) w_prod_flat[k*PW +: PW] = r_prod[k];
  end

  conv_add_tree #(
    .N  (KERNEL_NUM),
    .IW (PW)
  ) u_add_tree (
    .clk    (clk),
    .rst    (rst),
    .i_vld  (r_mul_vld),
    .i_data (w_prod_flat),
    .o_vld  (w_sum_vld),
    .o_sum  (w_sum)
  );

`ifdef CONV_RND_SAT_EN
  localparam logic [RW-1:0] RND_C   = (FRAC_WTH == 0) ? '0 :
                                      (RW'(1) << ((FRAC_WTH > 0) ? FRAC_WTH - 1 : 0));
  localparam logic [RW-1:0] SAT_MAX = (RW'(1) << COW) - RW'(1);

  always_comb begin
    w_ext = (RW'(w_sum) + RND_C) >> FRAC_WTH;
    w_res = (w_ext > SAT_MAX) ? '1 : COW'(w_ext);
  end
`else
  always_comb begin
    w_ext = RW'(w_sum) >> FRAC_WTH;
    w_res = COW'(w_ext);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      o_vld  <= 1'b0;
      o_data <= '0;
    end else begin
      o_vld <= w_sum_vld;
      if (w_sum_vld) o_data <= w_res;
    end
  end

endmodule

// File: doc/conv_krn_pipe.md
# conv_krn_pipe

Streaming KRNV_SZ x KRNH_SZ convolution engine, successor to the fixed 3x3/5x5 convolver in the bilateral-filter path. It accepts one vertical pixel column per valid cycle and keeps its own horizontal window, so no external column delay line is needed. Weights are double-buffered, with a runtime commit that takes effect only at a line boundary. A registered multiply / adder-tree / round-saturate pipeline drives `o_data` with a matching `o_vld`.

## Interface
- KRNV_SZ, 5, kernel rows (1..7)
- KRNH_SZ, 5, kernel columns (1..7)
- CIW, 8, unsigned pixel width
- FILTER_WTH, 8, unsigned weight width
- FRAC_WTH, 8, weight fractional bits; result is right-shifted by this amount
- COW, 12, output width
- KERNEL_NUM, KRNV_SZ*KRNH_SZ, tap count (derived, do not override)
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_vld  in  1  column valid
- i_hstr  in  1  first column of a line; qualified by i_vld
- i_data  in  CIW*KRNV_SZ  column; row r at bits [CIW*(r+1)-1 : CIW*r]
- i_wgt_wr  in  1  shadow weight write strobe
- i_wgt_addr  in  clog2(KERNEL_NUM)  tap index = h*KRNV_SZ + v
- i_wgt_data  in  FILTER_WTH  weight value
- i_wgt_cmt  in  1  commit request for the shadow bank
- o_data  out  COW  convolution result
- o_vld  out  1  o_data valid
- o_wgt_pend  out  1  commit requested but not yet applied

## Operation
- Column window: on each i_vld, columns shift in; the newest column is at h = KRNH_SZ-1.
- col_cnt: on i_vld with i_hstr it loads 1. On any other i_vld it increments and saturates at KRNH_SZ.
- A window is valid when the column being accepted brings col_cnt to KRNH_SZ. Partial windows at line start never produce o_vld.
- Result = sum over taps of pixel*weight. Accumulator width is CIW+FILTER_WTH+clog2(KERNEL_NUM), with no intermediate truncation.
- Post-scale: shift right by FRAC_WTH, then reduce to COW bits according to Configuration.
- Weight control FSM has two states, W_IDLE and W_PEND.
  - W_IDLE + i_wgt_cmt → W_PEND. o_wgt_pend = 1.
  - In W_PEND, on an i_vld & i_hstr cycle: shadow bank is copied to active bank, state → W_IDLE.
  - In W_IDLE, a commit raised on the same cycle as i_vld & i_hstr is applied that same cycle.
  - i_wgt_cmt while in W_PEND has no extra effect.
- Active weights are sampled together with the window, so every output uses one bank only.
  - The window completed by the first column of a line already uses the new bank.
- An i_wgt_wr on the same cycle as the applying commit is included in the copy (write-before-copy).
- Writes to the shadow bank never disturb the active bank.
- Reset mid-line: col_cnt = 0, all pipeline valids cleared, FSM → W_IDLE. In-flight results are discarded.

## Timing
- Reset values:
  - o_data = 0, o_vld = 0, o_wgt_pend = 0.
  - Active and shadow banks all 0, window registers 0.
- Pipeline stages:
  - input/window register: 1
  - multiply: 1
  - adder tree, registered per level: TREE_LVL = clog2(KERNEL_NUM)
  - round/saturate: 1
- Latency LAT = 3 + TREE_LVL, measured from the completing column to o_vld. 3x3 → 7 cycles; 5x5 → 8 cycles.
- No backpressure. Gaps in i_vld are allowed; o_vld follows the same gap pattern delayed by LAT.
- o_data holds its last value while o_vld = 0.
- o_wgt_pend rises the cycle after i_wgt_cmt and falls the cycle after the copy.

## Configuration
- CONV_RND_SAT_EN defined:
  - Rounding adds 2^(FRAC_WTH-1) before the shift (round half-up).
  - Results above 2^COW-1 clamp to 2^COW-1.
- Undefined: shift truncates, and the result keeps the low COW bits (wraps).
- Latency is identical in both builds.

## Structure
- Package conv_pkg holds:
  - clog2 function
  - TREE_LVL / LAT constant functions
  - weight FSM state enum (W_IDLE, W_PEND)
- Sub-module conv_add_tree: parametrised in input count and width, one register per level, carries a valid bit. The top level instantiates it once.

## Test plan
- 3x3, COW=8, FRAC=8, center weight 128 with all others 0, constant input 200 → o_data = 100. o_vld first rises LAT = 7 cycles after the third column of the line.
- 3x3, all weights 28, input 255, macro defined → o_data = 251. Exact sum 64260; +128 gives 64388; >>8 = 251.
- 3x3, COW=8, all weights 255, input 255 → 255 with macro defined; 238 without (2286 wraps).
- Commit mid-line, weights changing from center=128 to center=64 → o_wgt_pend = 1 until the next i_hstr. The first valid window of the next line reads 50 for input 200; there is no mixed-bank output.
- Line of 10 columns, 5x5 → exactly 6 o_vld pulses. An i_hstr arriving after 3 columns restarts the count, and no pulse comes from the 3-column fragment.
- Assert rst for one cycle with 4 results in flight → o_vld = 0 the next cycle. No stale output afterwards, and o_wgt_pend = 0.
